pipe_stage_reg: RTL and testbench

Generic, parametrised inter-stage pipeline register for the MIPS pipeline, the successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque data bundle and a control bundle between two stages. It adds a valid/ready handshake for stalls and flush-to-NOP with selectable sticky control bits that survive a flush, such as halt. It also has an optional skid entry, so that `in_ready` is driven from a register.

---
 rtl/pipe_stage_reg_pkg.sv | 40 ++++
 rtl/pipe_stage_reg_skid.sv | 58 +++++
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_pkg
// Description : Shared MIPS pipeline constants used by pipe_stage_reg and the
//               stages that instantiate it: control-bit positions, the NOP
//               control encoding, the sticky halt mask, per-stage bundle
//               widths and the occupancy counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

    // Control-bundle bit positions
    localparam int CTRL_REG_WRITE_BIT  = 0;
    localparam int CTRL_MEM_READ_BIT   = 1;
    localparam int CTRL_MEM_WRITE_BIT  = 2;
    localparam int CTRL_MEM_TO_REG_BIT = 3;
    localparam int CTRL_HALT_BIT       = 11;

    localparam int MIPS_CTRL_W = 12;

    // NOP: reg_write, mem_read and mem_write all deasserted
    localparam logic [MIPS_CTRL_W-1:0] MIPS_CTRL_NOP    = '0;
    localparam logic [MIPS_CTRL_W-1:0] STICKY_HALT_MASK =
        MIPS_CTRL_W'(1) << CTRL_HALT_BIT;

    // Per-stage bundle widths
    localparam int IF_ID_DATA_W  = 64;
    localparam int IF_ID_CTRL_W  = MIPS_CTRL_W;
    localparam int ID_EX_DATA_W  = 128;
    localparam int ID_EX_CTRL_W  = MIPS_CTRL_W;
    localparam int EX_MEM_DATA_W = 112;
    localparam int EX_MEM_CTRL_W = MIPS_CTRL_W;
    localparam int MEM_WB_DATA_W = 80;
    localparam int MEM_WB_CTRL_W = MIPS_CTRL_W;

    // Stage holds at most two entries
    localparam int OCC_W = 2;

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Single skid entry (valid, data, ctrl) sitting behind the main
//               entry of pipe_stage_reg. Only instantiated when
//               PIPE_STAGE_SKID_EN is defined.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               clear        - invalidate the entry (flush)
//               load         - capture load_data/load_ctrl
//               unload       - entry moved to main this cycle
//               valid/data/ctrl - stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              unload,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);
    import pipe_stage_reg_pkg::*;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Load wins over unload: a drain into main with a simultaneous new input
    // refills the skid in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
            r_ctrl  <= load_ctrl;
        end else if (unload) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;
    assign ctrl  = r_ctrl;

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic inter-stage pipeline register with valid/ready
//               handshake, flush-to-NOP with sticky control bits, and an
//               optional skid entry (macro PIPE_STAGE_SKID_EN) that makes
//               in_ready a registered signal.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               flush                 - drop contents, keep sticky bits
//               in_valid/in_ready     - upstream handshake
//               in_data/in_ctrl       - upstream bundles
//               out_valid/out_ready   - downstream handshake
//               out_data/out_ctrl     - registered bundles (0 / CTRL_NOP when
//                                       empty)
//               occupancy             - held entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 12,
    parameter logic [CTRL_W-1:0] CTRL_NOP    = '0,
    parameter logic [CTRL_W-1:0] STICKY_MASK = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;

    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    logic              w_in_xfer;
    logic              w_main_free;
    logic [CTRL_W-1:0] w_sticky;

    // Main can take a new entry when it is empty or its entry leaves now
    assign w_main_free = !r_main_valid || out_ready;
    assign w_in_xfer   = in_valid && in_ready;
    assign w_sticky    = in_ctrl & STICKY_MASK;

`ifdef PIPE_STAGE_SKID_EN
    // Registered ready: only the skid flop gates acceptance, so out_ready has
    // no combinational path here. Flush always consumes the upstream entry.
    assign in_ready = !w_skid_valid || flush;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .load      (w_in_xfer && !flush && (!w_main_free || w_skid_valid)),
        .unload    (w_main_free && w_skid_valid && !flush),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (w_skid_valid),
        .data      (w_skid_data),
        .ctrl      (w_skid_ctrl)
    );
`else
    assign in_ready     = w_main_free || flush;
    assign w_skid_valid = 1'b0;
    assign w_skid_data  = '0;
    assign w_skid_ctrl  = '0;
`endif

    // Main entry. Whenever it is invalid the data/ctrl flops hold 0/CTRL_NOP
    // so the outputs can be driven straight from the flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= CTRL_NOP;
        end else if (flush) begin
            if (in_valid && (w_sticky != '0)) begin
                r_main_valid <= 1'b1;
                r_main_data  <= '0;
                r_main_ctrl  <= CTRL_NOP | w_sticky;
            end else begin
                r_main_valid <= 1'b0;
                r_main_data  <= '0;
                r_main_ctrl  <= CTRL_NOP;
            end
        end else if (w_main_free) begin
            if (w_skid_valid) begin
                // Skid is older than anything upstream: it goes first
                r_main_valid <= 1'b1;
                r_main_data  <= w_skid_data;
                r_main_ctrl  <= w_skid_ctrl;
            end else if (w_in_xfer) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
                r_main_ctrl  <= in_ctrl;
            end else begin
                r_main_valid <= 1'b0;
                r_main_data  <= '0;
                r_main_ctrl  <= CTRL_NOP;
            end
        end
    end

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;
    assign occupancy = {1'b0, r_main_valid} + {1'b0, w_skid_valid};

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg. Works for
//               both builds (PIPE_STAGE_SKID_EN defined or not).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int                DW   = 16;
    localparam int                CW   = 12;
    localparam logic [CW-1:0]     NOP  = 12'h010;
    localparam logic [CW-1:0]     HALT = STICKY_HALT_MASK;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W      (DW),
        .CTRL_W      (CW),
        .CTRL_NOP    (NOP),
        .STICKY_MASK (HALT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fill the stage with out_ready held low: A in main, B in skid if present
    task automatic fill();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 12'h001;
        in_data   = 16'h00A;
        step();
        in_data   = 16'h00B;
        step();
        in_valid  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        check("fill_occ", 32'(occupancy), 32'd2);
`else
        check("fill_occ", 32'(occupancy), 32'd1);
`endif
    endtask

    initial begin
        // ---------------- reset with garbage on input ----------------
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 12'hFFF;
        in_data = 16'hFFFF; out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ctrl",  32'(out_ctrl),  32'(NOP));
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_occ",   32'(occupancy), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);

        // ---------------- streaming 1..4 ----------------
        out_ready = 1'b1; in_ctrl = 12'h001;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data",  32'(out_data),  32'(i));
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data",  32'(out_data),  32'd0);
        check("drain_ctrl",  32'(out_ctrl),  32'(NOP));

        // ---------------- stall ----------------
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'h002; in_data = 16'h00A;
        step();
        check("stall_a", 32'(out_data), 32'h00A);
        in_data = 16'h00B;
`ifdef PIPE_STAGE_SKID_EN
        #1;
        check("stall_rdy_b", 32'(in_ready), 32'd1);
        step();
        check("stall_occ2", 32'(occupancy), 32'd2);
        in_data = 16'h00C;
        #1;
        check("stall_rdy_c", 32'(in_ready), 32'd0);
        step();
        check("stall_hold_a", 32'(out_data), 32'h00A);
        check("stall_hold_occ", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        step();
        check("stall_out_b", 32'(out_data), 32'h00B);
        step();
        check("stall_out_c", 32'(out_data), 32'h00C);
`else
        #1;
        check("stall_rdy_b", 32'(in_ready), 32'd0);
        step();
        check("stall_hold_a", 32'(out_data), 32'h00A);
        check("stall_occ1", 32'(occupancy), 32'd1);
        out_ready = 1'b1;
        #1;
        check("stall_rdy_rel", 32'(in_ready), 32'd1);
        step();
        check("stall_out_b", 32'(out_data), 32'h00B);
        in_data = 16'h00C;
        step();
        check("stall_out_c", 32'(out_data), 32'h00C);
`endif
        in_valid = 1'b0;
        step();
        check("stall_empty", 32'(out_valid), 32'd0);

        // ---------------- flush with sticky halt ----------------
        fill();
        flush = 1'b1; in_valid = 1'b1; in_ctrl = HALT | 12'h001; in_data = 16'h0055;
        #1;
        check("flush_rdy", 32'(in_ready), 32'd1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("sticky_valid", 32'(out_valid), 32'd1);
        check("sticky_data",  32'(out_data),  32'd0);
        check("sticky_ctrl",  32'(out_ctrl),  32'(NOP | HALT));
        check("sticky_occ",   32'(occupancy), 32'd1);
        out_ready = 1'b1;
        step();
        check("sticky_drain", 32'(out_valid), 32'd0);

        // ---------------- flush without sticky ----------------
        fill();
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 12'h001; in_data = 16'h0066;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_occ",   32'(occupancy), 32'd0);
        check("flush_ctrl",  32'(out_ctrl),  32'(NOP));
        check("flush_data",  32'(out_data),  32'd0);

        // ---------------- reset + flush while full ----------------
        fill();
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_ctrl = HALT; in_data = 16'h0077;
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check("rstfl_valid", 32'(out_valid), 32'd0);
        check("rstfl_occ",   32'(occupancy), 32'd0);
        check("rstfl_ctrl",  32'(out_ctrl),  32'(NOP));
        check("rstfl_data",  32'(out_data),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
